// File: rtl/adbg_crc_seq_pkg.sv
// Shared types and constants for the debug-unit CRC32 burst sequencer.
package adbg_crc_seq_pkg;

    localparam int          CRC_W      = 32;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic        MODE_CHECK = 1'b0;
    localparam logic        MODE_GEN   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        DATA,
        TRAIL,
        DONE
    } state_e;

endpackage

// File: rtl/adbg_crc_seq_cnt.sv
// Loadable bit counter with terminal-count compare against a run-time limit.
// Shared by the payload and trailer phases of the CRC sequencer.
module adbg_crc_seq_cnt
    import adbg_crc_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear takes priority so a phase change on the final strobe restarts at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/adbg_crc_seq.sv
// Burst sequencer for the serial CRC32 engine: clear, payload feed, then trailer check/generate.
// Optional build macro ADBG_CRC_SEQ_SNAP_EN adds the crc_snap capture register.
module adbg_crc_seq
    import adbg_crc_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             tdo_out,
    output logic             crc_clr,
    output logic             crc_enable,
    output logic             crc_shift,
    output logic             crc_data,
    input  logic [CRC_W-1:0] crc_in,
    input  logic             crc_serial,
    output logic [CRC_W-1:0] crc_snap
);

    localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(CRC_W - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    logic             ok_q, ok_d;
    logic             fail_q, fail_d;

    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_limit;

    // len_q - 1 is only consulted in DATA, which is never entered with len_q == 0.
    assign cnt_limit = (state_q == TRAIL) ? TRAIL_LAST : (len_q - ONE);

    adbg_crc_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .limit_i (cnt_limit),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        err_d      = err_q;
        ok_d       = ok_q;
        fail_d     = fail_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        crc_clr    = 1'b0;
        crc_enable = 1'b0;
        crc_shift  = 1'b0;
        crc_data   = 1'b0;
        tdo_out    = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    mode_d  = mode;
                    len_d   = len;
                    err_d   = 1'b0;
                    ok_d    = 1'b0;
                    fail_d  = 1'b0;
                    state_d = CLR;
                end
            end

            CLR: begin
                crc_clr = 1'b1;
                cnt_clr = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = (len_q != '0) ? DATA : TRAIL;
                end
            end

            DATA: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_valid) begin
                    crc_enable = 1'b1;
                    crc_data   = bit_in;
                    if (cnt_tc) begin
                        cnt_clr = 1'b1;
                        state_d = TRAIL;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            TRAIL: begin
                tdo_out = (mode_q == MODE_GEN) ? crc_serial : 1'b0;
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_valid) begin
                    crc_shift = 1'b1;
                    if ((mode_q == MODE_CHECK) && (bit_in != crc_serial)) begin
                        err_d = 1'b1;
                    end
                    if (cnt_tc) begin
                        cnt_clr = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                if (!abort) begin
                    done   = 1'b1;
                    ok_d   = (mode_q == MODE_GEN) || !err_q;
                    fail_d = (mode_q == MODE_CHECK) && err_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            mode_q  <= MODE_CHECK;
            len_q   <= '0;
            err_q   <= 1'b0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
        end
    end

    // The verdict is visible alongside done, then held by the registers.
    assign busy    = (state_q != IDLE);
    assign crc_ok  = (state_q == DONE) ? ok_d : ok_q;
    assign crc_err = (state_q == DONE) ? fail_d : fail_q;

`ifdef ADBG_CRC_SEQ_SNAP_EN
    logic             trail_first_q;
    logic [CRC_W-1:0] snap_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            trail_first_q <= 1'b0;
            snap_q        <= '0;
        end else begin
            trail_first_q <= (state_d == TRAIL) && (state_q != TRAIL);
            if (trail_first_q) begin
                snap_q <= crc_in;
            end
        end
    end

    assign crc_snap = snap_q;
`else
    // Without the snapshot the parallel CRC value has no consumer here.
    logic unused_crc_in;
    assign unused_crc_in = ^crc_in;
    assign crc_snap      = '0;
`endif

endmodule

// File: tb/tb_adbg_crc_seq.sv
// Self-checking bench for adbg_crc_seq with a reflected CRC32 engine model attached.
module tb_adbg_crc_seq;

    localparam int          CNT_W = 16;
    localparam logic [31:0] POLY  = 32'hEDB88320;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] len = '0;
    logic        abort = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        busy, done, crc_ok, crc_err, tdo_out;
    logic        crc_clr, crc_enable, crc_shift, crc_data;
    logic [31:0] crc_in;
    logic        crc_serial;
    logic [31:0] crc_snap;
    logic [31:0] eng = '0;

    int n_checks = 0;
    int n_fail = 0;
    int n_en, n_sh, n_clr, n_done, n_excl;

    always #5 clk = ~clk;

    adbg_crc_seq #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .mode       (mode),
        .len        (len),
        .abort      (abort),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .busy       (busy),
        .done       (done),
        .crc_ok     (crc_ok),
        .crc_err    (crc_err),
        .tdo_out    (tdo_out),
        .crc_clr    (crc_clr),
        .crc_enable (crc_enable),
        .crc_shift  (crc_shift),
        .crc_data   (crc_data),
        .crc_in     (crc_in),
        .crc_serial (crc_serial),
        .crc_snap   (crc_snap)
    );

    // External serial CRC32 datapath the sequencer drives.
    always @(posedge clk) begin
        if (crc_clr)         eng <= 32'hFFFFFFFF;
        else if (crc_enable) eng <= {1'b0, eng[31:1]} ^ ({32{eng[0] ^ crc_data}} & POLY);
        else if (crc_shift)  eng <= {1'b0, eng[31:1]};
    end
    assign crc_in     = eng;
    assign crc_serial = eng[0];

    // Reference CRC of the first l payload bits, LSB first.
    function automatic logic [31:0] ref_crc(input logic [31:0] pay, input int l);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < l; i++) begin
            fb = c[0] ^ pay[i];
            c  = c >> 1;
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        n_en = 0; n_sh = 0; n_clr = 0; n_done = 0; n_excl = 0;
    endtask

    task automatic cyc(input logic st, input logic ab, input logic bv, input logic bi);
        @(negedge clk);
        start = st; abort = ab; bit_valid = bv; bit_in = bi;
        #1;
        if (crc_enable) n_en++;
        if (crc_shift)  n_sh++;
        if (crc_clr)    n_clr++;
        if (done)       n_done++;
        if ((int'(crc_enable) + int'(crc_shift) + int'(crc_clr)) > 1) n_excl++;
    endtask

    task automatic burst(input logic m, input int l, input logic [31:0] pay, input logic [31:0] tr,
                         input int gap, input bit poke, input logic exp_ok, input string tag);
        logic [31:0] ref_v, tdo_bits, exp_snap;
        logic        got_done, got_ok, got_err, bi;
        ref_v    = ref_crc(pay, l);
        tdo_bits = '0;
        clr_counts();
        mode = m;
        len  = 16'(l);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        if (poke) begin
            len  = len + 16'd5;
            mode = ~m;
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int s = 0; s < l + 32; s++) begin
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
            bi = (s < l) ? pay[s] : tr[s - l];
            cyc(1'b0, 1'b0, 1'b1, bi);
            if (s >= l) tdo_bits[s - l] = tdo_out;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        got_done = done; got_ok = crc_ok; got_err = crc_err;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, ".done_lat"}, 64'(got_done), 64'(1));
        chk({tag, ".done_cnt"}, 64'(n_done), 64'(1));
        chk({tag, ".en_cnt"}, 64'(n_en), 64'(l));
        chk({tag, ".shift_cnt"}, 64'(n_sh), 64'(32));
        chk({tag, ".clr_cnt"}, 64'(n_clr), 64'(1));
        chk({tag, ".exclusive"}, 64'(n_excl), 64'(0));
        chk({tag, ".crc_ok"}, 64'(got_ok), 64'(exp_ok));
        chk({tag, ".crc_err"}, 64'(got_err), 64'(!exp_ok));
        if (m) chk({tag, ".tdo"}, 64'(tdo_bits), 64'(ref_v));
        chk({tag, ".busy_after"}, 64'(busy), 64'(0));
        chk({tag, ".ok_held"}, 64'(crc_ok), 64'(exp_ok));
`ifdef ADBG_CRC_SEQ_SNAP_EN
        exp_snap = ref_v;
`else
        exp_snap = 32'h0;
`endif
        chk({tag, ".snap"}, 64'(crc_snap), 64'(exp_snap));
        $display("burst %s mode=%0d len=%0d ok=%0b err=%0b tdo=%08h", tag, m, l, got_ok, got_err, tdo_bits);
    endtask

    typedef struct {
        logic        m;
        int          l;
        logic [31:0] pay;
        int          sel;
        int          gap;
        bit          poke;
        logic        exp_ok;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [31:0] tr, ref_v;
        logic        m, exp_ok;
        int          l, idx;

        vecs[0] = '{1'b1, 0,  32'h0,    0, 0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 0,  32'h0,    1, 0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 0,  32'h0,    2, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8,  32'hA5,   0, 0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8,  32'hA5,   0, 0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8,  32'hA5,   3, 0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 16, 32'h1234, 0, 2, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1,  32'h1,    0, 1, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 4,  32'h9,    0, 0, 1'b1, 1'b1};
        vecs[9] = '{1'b1, 16, 32'hFFFF, 1, 0, 1'b1, 1'b1};

        // Reset state
        clr_counts();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.outputs",
            64'({busy, done, crc_ok, crc_err, tdo_out, crc_clr, crc_enable, crc_shift, crc_data}), 64'(0));
        chk("reset.snap", 64'(crc_snap), 64'(0));
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        for (int v = 0; v < 10; v++) begin
            case (vecs[v].sel)
                0:       tr = ref_crc(vecs[v].pay, vecs[v].l);
                1:       tr = 32'hFFFFFFFF;
                2:       tr = 32'hFFFFFFDF;
                default: tr = ref_crc(vecs[v].pay ^ 32'h1, vecs[v].l);
            endcase
            burst(vecs[v].m, vecs[v].l, vecs[v].pay, tr, vecs[v].gap, vecs[v].poke,
                  vecs[v].exp_ok, $sformatf("vec%0d", v));
        end

        // Abort on the 5th payload strobe
        clr_counts();
        mode = 1'b0; len = 16'd10;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'(i));
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("abort.enable_blocked", 64'(crc_enable), 64'(0));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort.busy", 64'(busy), 64'(0));
        chk("abort.ok_cleared", 64'({crc_ok, crc_err}), 64'(0));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("abort.no_done", 64'(n_done), 64'(0));
        chk("abort.en_cnt", 64'(n_en), 64'(4));
        $display("seq abort busy=%0b done_cnt=%0d", busy, n_done);
        burst(1'b0, 8, 32'hA5, ref_crc(32'hA5, 8), 0, 1'b0, 1'b1, "post_abort");

        // Reset during TRAIL
        clr_counts();
        mode = 1'b1; len = 16'd0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        rstn = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_trail.busy", 64'(busy), 64'(0));
        chk("rst_trail.outputs", 64'({done, crc_ok, crc_err, tdo_out, crc_shift}), 64'(0));
        chk("rst_trail.snap", 64'(crc_snap), 64'(0));
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_trail.no_done", 64'(n_done), 64'(0));
        $display("seq reset_in_trail busy=%0b done_cnt=%0d", busy, n_done);
        burst(1'b1, 0, 32'h0, 32'h0, 0, 1'b0, 1'b1, "post_reset");

        // start and abort together in IDLE
        clr_counts();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_abort.busy", 64'(busy), 64'(0));
        chk("start_abort.clr", 64'(n_clr), 64'(0));
        $display("seq start_with_abort busy=%0b clr_cnt=%0d", busy, n_clr);

        // Randomized bursts against the reference
        for (int r = 0; r < 24; r++) begin
            m     = 1'($urandom_range(0, 1));
            l     = int'($urandom_range(0, 24));
            ref_v = $urandom;
            tr    = ref_crc(ref_v, l);
            if ($urandom_range(0, 1) == 1) begin
                idx = int'($urandom_range(0, 31));
                tr[idx] = ~tr[idx];
            end
            exp_ok = m ? 1'b1 : (tr == ref_crc(ref_v, l));
            burst(m, l, ref_v, tr, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  exp_ok, $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adbg_crc_seq.md
Name: adbg_crc_seq

Overview:
Sequencer for the debug unit's serial CRC32 engine. On each burst it clears the engine, feeds it a programmed number of payload bits, then either checks or generates a trailer:
- Check mode: compares 32 received trailer bits against the computed CRC.
- Generate mode: shifts the computed CRC out serially.

Sits between the JTAG shift/data-register logic and the CRC32 datapath; drives the engine's clr/enable/shift/data and reads back its crc_out/serial_out.

Parameters:
- CNT_W, 16: width of payload bit-length and internal bit counter.
- CRC_W, 32: trailer length in bits; fixed to 32 for this engine.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle burst request; sampled in IDLE only.
- mode  in  1  0 = check trailer, 1 = generate trailer; latched at start.
- len  in  CNT_W  payload bit count; latched at start; 0 allowed.
- abort  in  1  cancel burst; return to IDLE without done.
- bit_valid  in  1  serial bit strobe (one per shifted bit).
- bit_in  in  1  serial payload/trailer bit, valid with bit_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at burst end.
- crc_ok  out  1  check passed; held until next accepted start.
- crc_err  out  1  check failed; held until next accepted start.
- tdo_out  out  1  generated trailer bit (gen mode), else 0.
- crc_clr  out  1  to engine clr.
- crc_enable  out  1  to engine enable.
- crc_shift  out  1  to engine shift.
- crc_data  out  1  to engine data.
- crc_in  in  CRC_W  from engine crc_out.
- crc_serial  in  1  from engine serial_out (crc_in[0]).
- crc_snap  out  CRC_W  captured CRC (optional feature).

Behaviour:
- Reset (rstn=0 at clk edge): state IDLE; counter 0; all outputs 0. Applies mid-burst identically.
- States: IDLE, CLR, DATA, TRAIL, DONE.
- IDLE:
  - start=1 → latch mode/len; clear crc_ok, crc_err and the internal err flag; go to CLR.
  - start while busy is ignored.
- CLR: crc_clr=1 for exactly one cycle; counter ← 0. Next state is DATA if len≠0, else TRAIL.
- DATA: while bit_valid=1, crc_enable=1 and crc_data=bit_in combinationally, and counter++. On the strobe where counter==len-1, go to TRAIL with counter ← 0.
- TRAIL (identical for both modes): each bit_valid asserts crc_shift=1 for that cycle and counter++. After the strobe with counter==CRC_W-1, go to DONE.
  - Check mode: bit_in is compared with crc_serial; a mismatch sets the sticky err flag.
  - Generate mode: tdo_out=crc_serial combinationally.
- DONE: done=1 for one cycle. Check mode: crc_ok=!err, crc_err=err. Generate mode: crc_ok=1, crc_err=0. Next state IDLE.
- crc_enable, crc_shift and crc_clr are mutually exclusive; never more than one is high in a cycle.
- bit_valid outside DATA/TRAIL is ignored.
- abort has priority over bit_valid in all non-IDLE states: next state IDLE, no done, crc_ok/crc_err stay 0.
- start and abort together in IDLE: abort wins and start is dropped.
- Latency:
  - start → first accepted payload bit: 2 cycles (CLR, then DATA).
  - Last trailer strobe → done: 1 cycle.
- Bit counter wraps only through reload; len up to 2^CNT_W-1 supported.

Optional Feature:
- ADBG_CRC_SEQ_SNAP_EN defined: crc_snap is a register loaded with crc_in in the first cycle of TRAIL, before any shift; it is reset to 0 and holds until the next TRAIL.
- Undefined: crc_snap is tied to 0 and no register is inferred.

Decomposition:
- Package adbg_crc_seq_pkg: state enum (IDLE, CLR, DATA, TRAIL, DONE), CRC_W=32, CRC_INIT=32'hFFFFFFFF, MODE_CHECK=1'b0, MODE_GEN=1'b1.
- One natural sub-module, adbg_crc_seq_cnt: loadable bit counter with terminal-count compare against a run-time limit, used for both payload and trailer phases.
- The CRC32 engine itself is instantiated by the parent, not inside this block.

Test Plan:
- gen, len=0, 32 consecutive bit_valid → tdo_out=1 on all 32 (CRC_INIT shifted out); done pulses 1 cycle after the 32nd strobe; crc_ok=1.
- check, len=0, bit_in=1 ×32 → crc_ok=1, crc_err=0. Repeat with bit 5 of the trailer =0 → crc_err=1, crc_ok=0.
- gen, len=8, payload 0xA5 LSB-first, capture the 32 tdo bits; then check with the same payload plus the captured trailer → crc_ok=1. Flip one payload bit → crc_err=1.
- check, len=16, bit_valid gapped (1 of every 3 cycles) → exactly 16 crc_enable pulses and 32 crc_shift pulses; enable/shift/clr never concurrent.
- abort on the 5th payload strobe, and separately rstn=0 during TRAIL → IDLE next cycle, done never pulses, busy=0; a following start works normally.
- start asserted while busy → ignored, latched len unchanged. With ADBG_CRC_SEQ_SNAP_EN, len=0 → crc_snap=32'hFFFFFFFF after TRAIL entry.
